fizzbuzz_stream: RTL and testbench

//  Parametrised fizzbuzz sequence generator with a valid/ready output stream.

---
 rtl/fizzbuzz_pkg.sv | 13 +
 rtl/fizzbuzz_stream_phase.sv | 42 ++++
 rtl/fizzbuzz_stream.sv | 135 +++++++++++++
 tb/tb_fizzbuzz_stream.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fizzbuzz_pkg.sv
// Shared types and helpers for the fizzbuzz stream generator.
package fizzbuzz_pkg;

  typedef enum logic {
    FB_IDLE,
    FB_RUN
  } fb_state_t;

  function automatic int fb_width(int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/fizzbuzz_stream_phase.sv
// Modulo-N phase counter: tracks n mod G_MOD without a divider.
// Load forces phase 1, advance steps and wraps G_MOD-1 -> 0.
module mod_phase_counter
  import fizzbuzz_pkg::*;
#(
  parameter int G_MOD = 3,
  localparam int PW = $clog2(G_MOD)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_load,
  input  logic          i_adv,
  output logic [PW-1:0] o_phase,
  output logic          o_zero
);

  localparam logic [PW-1:0] LAST = PW'(G_MOD - 1);

  logic [PW-1:0] phase_d;
  logic [PW-1:0] phase_q;

  always_comb begin
    phase_d = phase_q;
    if (i_load) begin
      phase_d = PW'(1);
    end else if (i_adv) begin
      phase_d = (phase_q == LAST) ? '0 : phase_q + PW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign o_phase = phase_q;
  assign o_zero  = (phase_q == '0);

endmodule

// File: rtl/fizzbuzz_stream.sv
// Fizzbuzz number stream with valid/ready output, wrap and abort.
// Numbers 1..G_LENGTH, flags from two phase counters.
module fizzbuzz_stream
  import fizzbuzz_pkg::*;
#(
  parameter int G_LENGTH   = 50,
  parameter int G_FIZZ_DIV = 3,
  parameter int G_BUZZ_DIV = 5,
  localparam int W = fb_width(G_LENGTH)
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic         i_continuous,
  input  logic         i_abort,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_number,
  output logic         o_is_fizz,
  output logic         o_is_buzz,
  output logic         o_last,
  output logic         o_busy
);

  if (G_LENGTH < 1) begin : g_bad_len
    $error("fizzbuzz_stream: G_LENGTH must be >= 1");
  end
  if (G_FIZZ_DIV < 2) begin : g_bad_fizz
    $error("fizzbuzz_stream: G_FIZZ_DIV must be >= 2");
  end
  if (G_BUZZ_DIV < 2) begin : g_bad_buzz
    $error("fizzbuzz_stream: G_BUZZ_DIV must be >= 2");
  end

  localparam logic [W-1:0] LEN = W'(G_LENGTH);
  localparam logic [W-1:0] ONE = W'(1);

  fb_state_t    state_d, state_q;
  logic [W-1:0] number_d, number_q;
  logic         last_d, last_q;
  logic         cont_d, cont_q;
  logic         ph_load;
  logic         ph_adv;
  logic         fizz_zero;
  logic         buzz_zero;
  logic         xfer;

  logic [$clog2(G_FIZZ_DIV)-1:0] fizz_phase_unused;
  logic [$clog2(G_BUZZ_DIV)-1:0] buzz_phase_unused;

  assign xfer = (state_q == FB_RUN) & i_ready;

  always_comb begin
    state_d  = state_q;
    number_d = number_q;
    last_d   = last_q;
    cont_d   = cont_q;
    ph_load  = 1'b0;
    ph_adv   = 1'b0;
    unique case (state_q)
      FB_IDLE: begin
        if (i_start) begin
          state_d  = FB_RUN;
          number_d = ONE;
          last_d   = (ONE == LEN);
          cont_d   = i_continuous;
          ph_load  = 1'b1;
        end
      end
      FB_RUN: begin
        if (i_abort) begin
          state_d  = FB_IDLE;
          number_d = '0;
          last_d   = 1'b0;
        end else if (xfer) begin
          if (!last_q) begin
            number_d = number_q + ONE;
            last_d   = (number_q + ONE == LEN);
            ph_adv   = 1'b1;
          end else if (cont_q) begin
            number_d = ONE;
            last_d   = (ONE == LEN);
            ph_load  = 1'b1;
          end else begin
            state_d  = FB_IDLE;
            number_d = '0;
            last_d   = 1'b0;
          end
        end
      end
      default: state_d = FB_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= FB_IDLE;
      number_q <= '0;
      last_q   <= 1'b0;
      cont_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      number_q <= number_d;
      last_q   <= last_d;
      cont_q   <= cont_d;
    end
  end

  mod_phase_counter #(.G_MOD(G_FIZZ_DIV)) u_fizz (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (ph_load),
    .i_adv   (ph_adv),
    .o_phase (fizz_phase_unused),
    .o_zero  (fizz_zero)
  );

  mod_phase_counter #(.G_MOD(G_BUZZ_DIV)) u_buzz (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (ph_load),
    .i_adv   (ph_adv),
    .o_phase (buzz_phase_unused),
    .o_zero  (buzz_zero)
  );

  // Phases are stale outside a run, so flags are masked by valid.
  assign o_valid   = (state_q == FB_RUN);
  assign o_busy    = (state_q == FB_RUN);
  assign o_number  = number_q;
  assign o_last    = last_q;
  assign o_is_fizz = o_valid & fizz_zero;
  assign o_is_buzz = o_valid & buzz_zero;

endmodule

// File: tb/tb_fizzbuzz_stream.sv
// Directed bench: default 50/3/5 instance plus a 7/2/7 instance.
module tb_fizzbuzz_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, cont, abort, ready;
  logic       valid, fizz, buzz, last, busy;
  logic [5:0] num;

  logic       start_b, ready_b;
  logic       valid_b, fizz_b, buzz_b, last_b, busy_b;
  logic [2:0] num_b;

  fizzbuzz_stream dut_a (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_continuous (cont),
    .i_abort      (abort),
    .i_ready      (ready),
    .o_valid      (valid),
    .o_number     (num),
    .o_is_fizz    (fizz),
    .o_is_buzz    (buzz),
    .o_last       (last),
    .o_busy       (busy)
  );

  fizzbuzz_stream #(
    .G_LENGTH   (7),
    .G_FIZZ_DIV (2),
    .G_BUZZ_DIV (7)
  ) dut_b (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start_b),
    .i_continuous (1'b0),
    .i_abort      (1'b0),
    .i_ready      (ready_b),
    .o_valid      (valid_b),
    .o_number     (num_b),
    .o_is_fizz    (fizz_b),
    .o_is_buzz    (buzz_b),
    .o_last       (last_b),
    .o_busy       (busy_b)
  );

  typedef struct {
    logic       start;
    logic       ready;
    logic       v;
    logic       b;
    logic       l;
    logic       f;
    logic       z;
    logic [2:0] n;
  } vec_t;

  int n_chk  = 0;
  int n_fail = 0;

  function automatic int pk(logic v, logic b, logic l,
                            logic f, logic z, logic [5:0] n);
    return {21'd0, v, b, l, f, z, n};
  endfunction

  function automatic int beat(int n, int len, int fd, int bd);
    return pk(1'b1, 1'b1, n == len, n % fd == 0, n % bd == 0, 6'(n));
  endfunction

  function automatic int cur_a();
    return pk(valid, busy, last, fizz, buzz, num);
  endfunction

  function automatic int cur_b();
    return pk(valid_b, busy_b, last_b, fizz_b, buzz_b, 6'(num_b));
  endfunction

  function automatic vec_t mk(logic s, logic r, logic v, logic b,
                              logic l, logic f, logic z, logic [2:0] n);
    vec_t t;
    t.start = s; t.ready = r; t.v = v; t.b = b;
    t.l = l; t.f = f; t.z = z; t.n = n;
    return t;
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t tv[12];

  initial begin
    int fz, bz, n, nexp, r;
    bit found;

    tv[0]  = mk(1, 1, 1, 1, 0, 0, 0, 3'd1);
    tv[1]  = mk(0, 1, 1, 1, 0, 1, 0, 3'd2);
    tv[2]  = mk(0, 0, 1, 1, 0, 1, 0, 3'd2);
    tv[3]  = mk(0, 1, 1, 1, 0, 0, 0, 3'd3);
    tv[4]  = mk(0, 1, 1, 1, 0, 1, 0, 3'd4);
    tv[5]  = mk(0, 1, 1, 1, 0, 0, 0, 3'd5);
    tv[6]  = mk(0, 1, 1, 1, 0, 1, 0, 3'd6);
    tv[7]  = mk(1, 1, 1, 1, 1, 0, 1, 3'd7);
    tv[8]  = mk(0, 0, 1, 1, 1, 0, 1, 3'd7);
    tv[9]  = mk(0, 1, 0, 0, 0, 0, 0, 3'd0);
    tv[10] = mk(1, 1, 1, 1, 0, 0, 0, 3'd1);
    tv[11] = mk(0, 1, 1, 1, 0, 1, 0, 3'd2);

    rst = 1; start = 0; cont = 0; abort = 0; ready = 0;
    start_b = 0; ready_b = 0;
    #1;
    tick(); tick();
    chk("reset_a", cur_a(), 0);
    chk("reset_b", cur_b(), 0);
    rst = 0;
    tick();
    abort = 1;
    tick();
    abort = 0;
    chk("idle_abort", cur_a(), 0);

    // one-shot, always ready
    ready = 1; start = 1;
    tick();
    start = 0;
    fz = 0; bz = 0;
    for (int i = 1; i <= 50; i++) begin
      chk("t1_beat", cur_a(), beat(i, 50, 3, 5));
      if (fizz) fz++;
      if (buzz) bz++;
      tick();
    end
    chk("t1_idle", cur_a(), 0);
    chk("t1_fizz_cnt", fz, 16);
    chk("t1_buzz_cnt", bz, 10);

    // stall at 7
    start = 1;
    tick();
    start = 0;
    for (int i = 1; i <= 50; i++) begin
      chk("t2_beat", cur_a(), beat(i, 50, 3, 5));
      if (i == 7) begin
        ready = 0;
        for (int k = 0; k < 4; k++) begin
          tick();
          chk("t2_hold", cur_a(), beat(7, 50, 3, 5));
        end
        ready = 1;
      end
      tick();
    end
    chk("t2_idle", cur_a(), 0);

    // continuous with ignored start pulse
    cont = 1; start = 1;
    tick();
    start = 0; cont = 0;
    for (int i = 0; i < 53; i++) begin
      n = (i % 50) + 1;
      chk("t3_beat", cur_a(), beat(n, 50, 3, 5));
      start = (i == 9 || i == 49);
      tick();
    end
    start = 0;
    abort = 1;
    tick();
    abort = 0;
    chk("t3_abort", cur_a(), 0);

    // abort while stalled at 20
    start = 1;
    tick();
    start = 0;
    for (int i = 1; i < 20; i++) begin
      chk("t4_beat", cur_a(), beat(i, 50, 3, 5));
      tick();
    end
    chk("t4_at20", cur_a(), beat(20, 50, 3, 5));
    ready = 0;
    tick();
    chk("t4_stall", cur_a(), beat(20, 50, 3, 5));
    abort = 1;
    tick();
    abort = 0;
    chk("t4_abort", cur_a(), 0);
    ready = 1; start = 1;
    tick();
    start = 0;
    chk("t4_restart", cur_a(), beat(1, 50, 3, 5));
    abort = 1;
    tick();
    abort = 0;
    chk("t4_abort2", cur_a(), 0);

    // reset at 33 under random ready
    start = 1; ready = 1;
    tick();
    start = 0;
    nexp = 1;
    found = 0;
    for (int c = 0; c < 2000; c++) begin
      chk("t5_seq", cur_a(), beat(nexp, 50, 3, 5));
      if (num == 6'd33) begin
        found = 1;
        break;
      end
      r = int'($urandom_range(0, 1));
      ready = r[0];
      tick();
      if (r[0]) nexp++;
    end
    if (!found) chk("t5_timeout", 0, 1);
    rst = 1;
    ready = 1'($urandom_range(0, 1));
    tick();
    chk("t5_reset", cur_a(), 0);
    rst = 0;
    ready = 1;
    tick();
    chk("t5_after", cur_a(), 0);

    // small-parameter instance, table driven
    for (int i = 0; i < 12; i++) begin
      start_b = tv[i].start;
      ready_b = tv[i].ready;
      tick();
      chk($sformatf("t6_vec%0d", i), cur_b(),
          pk(tv[i].v, tv[i].b, tv[i].l, tv[i].f, tv[i].z,
             6'(tv[i].n)));
    end
    start_b = 0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
